// File: rtl/jtframe_pkg.sv
// Shared encodings for the frame reset-request logic: cause codes, FSM states
// and the width of the hold/cool counter.
package jtframe_pkg;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_BTN  = 2'd1,
        CAUSE_OSD  = 2'd2,
        CAUSE_WDOG = 2'd3
    } cause_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_COOL   = 2'd2
    } state_t;

    // Wide enough for both HOLD (<=255) and COOL (<=65535).
    localparam int CNT_W = 16;

endpackage

// File: rtl/jtframe_debounce.sv
// Two-flop synchroniser plus stability counter for an asynchronous button.
// level follows the synchronised input once it has differed for DEB cycles.
module jtframe_debounce #(
    parameter int DEB = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);
    localparam int CW = $clog2(DEB) + 1;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        // Counting only while the input disagrees; any return to agreement restarts it.
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEB - 1)) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/jtframe_rstreq.sv
// Merges button, OSD and watchdog reset sources into one stretched,
// rate-limited rst_req pulse and remembers which source caused it.
module jtframe_rstreq
    import jtframe_pkg::*;
#(
    parameter int DEB  = 16,
    parameter int WDW  = 20,
    parameter int HOLD = 8,
    parameter int COOL = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_rst,
    input  logic       osd_rst,
    input  logic       wdog_en,
    input  logic       wdog_kick,
    input  logic       downloading,
    output logic       rst_req,
    output logic       busy,
    output logic [1:0] cause
);
    logic             btn_level;
    logic             btn_ev;
    logic             osd_prev_q, osd_prev_d;
    logic             osd_ev;
    logic [WDW-1:0]   wd_q, wd_d;
    logic             wd_run;
    logic             wd_ev;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cause_t           cause_q, cause_d;
    logic             rst_req_q, rst_req_d;
    logic             busy_q, busy_d;

    jtframe_debounce #(.DEB(DEB)) u_btn (
        .clk   (clk),
        .rst   (rst),
        .din   (btn_rst),
        .level (btn_level),
        .rise  (btn_ev)
    );

    assign osd_prev_d = osd_rst;
    assign osd_ev     = osd_rst & ~osd_prev_q;

    // A kick in the terminal-count cycle suppresses the trip because it stops wd_run.
    assign wd_run = wdog_en & ~downloading & ~wdog_kick & (state_q == ST_IDLE);
    assign wd_ev  = wd_run & (&wd_q);
    assign wd_d   = (!wd_run || (&wd_q)) ? '0 : wd_q + WDW'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cause_d   = cause_q;
        rst_req_d = rst_req_q;
        busy_d    = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (btn_ev || osd_ev || wd_ev) begin
                    state_d   = ST_ASSERT;
                    cnt_d     = '0;
                    rst_req_d = 1'b1;
                    busy_d    = 1'b1;
                    cause_d   = btn_ev ? CAUSE_BTN : (osd_ev ? CAUSE_OSD : CAUSE_WDOG);
                end
            end
            ST_ASSERT: begin
                if (cnt_q == CNT_W'(HOLD - 1)) begin
                    cnt_d     = '0;
                    rst_req_d = 1'b0;
                    if (COOL == 0) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_COOL;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_COOL: begin
                if (cnt_q == CNT_W'(COOL - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                rst_req_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            osd_prev_q <= 1'b0;
            wd_q       <= '0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cause_q    <= CAUSE_NONE;
            rst_req_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            osd_prev_q <= osd_prev_d;
            wd_q       <= wd_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cause_q    <= cause_d;
            rst_req_q  <= rst_req_d;
            busy_q     <= busy_d;
        end
    end

    assign rst_req = rst_req_q;
    assign busy    = busy_q;
    assign cause   = cause_q;

    logic unused_level;
    assign unused_level = btn_level;

endmodule

// File: tb/tb_jtframe_rstreq.sv
// Directed bench for jtframe_rstreq with DEB=4, WDW=6, HOLD=8, COOL=16.
module tb_jtframe_rstreq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_rst = 1'b0;
    logic       osd_rst = 1'b0;
    logic       wdog_en = 1'b0;
    logic       wdog_kick = 1'b0;
    logic       downloading = 1'b0;
    logic       rst_req;
    logic       busy;
    logic [1:0] cause;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jtframe_rstreq #(.DEB(4), .WDW(6), .HOLD(8), .COOL(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_rst     (btn_rst),
        .osd_rst     (osd_rst),
        .wdog_en     (wdog_en),
        .wdog_kick   (wdog_kick),
        .downloading (downloading),
        .rst_req     (rst_req),
        .busy        (busy),
        .cause       (cause)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (rst_req !== 1'b0) begin failures++; $display("FAIL reset_rst_req: got %b expected 0", rst_req); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (cause !== 2'd0) begin failures++; $display("FAIL reset_cause: got %0d expected 0", cause); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_button();
        int n, w, c, hi;
        btn_rst = 1'b1;
        tick();
        tick();
        btn_rst = 1'b0;
        tick();
        tick();
        btn_rst = 1'b1;
        n = 0;
        while (!rst_req && n < 40) begin tick(); n++; end
        checks++;
        if (n !== 7) begin failures++; $display("FAIL btn_latency: got %0d cycles expected 7", n); end
        w = 0;
        while (rst_req && w < 40) begin tick(); w++; end
        checks++;
        if (w !== 8) begin failures++; $display("FAIL btn_pulse_width: got %0d expected 8", w); end
        c = 0;
        while (busy && c < 60) begin tick(); c++; end
        checks++;
        if (c !== 16) begin failures++; $display("FAIL btn_cool_len: got %0d expected 16", c); end
        checks++;
        if (cause !== 2'd1) begin failures++; $display("FAIL btn_cause: got %0d expected 1", cause); end
        hi = 0;
        repeat (30) begin tick(); if (rst_req) hi++; end
        checks++;
        if (hi !== 0) begin failures++; $display("FAIL btn_held_repeat: got %0d high cycles expected 0", hi); end
        btn_rst = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_osd_cool();
        int hi, rises;
        logic prev;
        hi = 0;
        rises = 0;
        prev = 1'b0;
        for (int i = 0; i < 40; i++) begin
            osd_rst = (i == 0 || i == 10);
            tick();
            if (rst_req) hi++;
            if (rst_req && !prev) rises++;
            prev = rst_req;
        end
        osd_rst = 1'b0;
        checks++;
        if (hi !== 8) begin failures++; $display("FAIL osd_pulse_width: got %0d expected 8", hi); end
        checks++;
        if (rises !== 1) begin failures++; $display("FAIL osd_cool_drop: got %0d pulses expected 1", rises); end
        checks++;
        if (cause !== 2'd2) begin failures++; $display("FAIL osd_cause: got %0d expected 2", cause); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL osd_idle_after: busy got %b expected 0", busy); end
    endtask

    task automatic test_watchdog();
        int n, c, hi;
        wdog_en = 1'b1;
        n = 0;
        while (!rst_req && n < 100) begin tick(); n++; end
        checks++;
        if (n !== 64) begin failures++; $display("FAIL wdog_trip_cycle: got %0d expected 64", n); end
        checks++;
        if (cause !== 2'd3) begin failures++; $display("FAIL wdog_cause: got %0d expected 3", cause); end
        c = 0;
        while (busy && c < 60) begin tick(); c++; end
        checks++;
        if (c !== 24) begin failures++; $display("FAIL wdog_busy_len: got %0d expected 24", c); end
        hi = 0;
        for (int i = 0; i < 1000; i++) begin
            wdog_kick = (i % 50 == 0);
            tick();
            if (rst_req) hi++;
        end
        wdog_kick = 1'b0;
        checks++;
        if (hi !== 0) begin failures++; $display("FAIL wdog_kicked: got %0d high cycles expected 0", hi); end
        hi = 0;
        wdog_kick = 1'b1;
        tick();
        wdog_kick = 1'b0;
        repeat (63) begin tick(); if (rst_req) hi++; end
        wdog_kick = 1'b1;
        tick();
        wdog_kick = 1'b0;
        repeat (20) begin tick(); if (rst_req) hi++; end
        checks++;
        if (hi !== 0) begin failures++; $display("FAIL wdog_kick_at_terminal: got %0d high cycles expected 0", hi); end
        wdog_en = 1'b0;
        tick();
    endtask

    task automatic test_simultaneous();
        int w, c, hi;
        btn_rst = 1'b1;
        repeat (6) tick();
        osd_rst = 1'b1;
        tick();
        osd_rst = 1'b0;
        checks++;
        if (rst_req !== 1'b1) begin failures++; $display("FAIL simul_req: got %b expected 1", rst_req); end
        checks++;
        if (cause !== 2'd1) begin failures++; $display("FAIL simul_cause: got %0d expected 1", cause); end
        w = 0;
        while (rst_req && w < 40) begin w++; tick(); end
        checks++;
        if (w !== 8) begin failures++; $display("FAIL simul_width: got %0d expected 8", w); end
        c = 0;
        while (busy && c < 60) begin tick(); c++; end
        hi = 0;
        repeat (20) begin tick(); if (rst_req) hi++; end
        checks++;
        if (hi !== 0) begin failures++; $display("FAIL simul_single: got %0d extra high cycles expected 0", hi); end
        checks++;
        if (cause !== 2'd1) begin failures++; $display("FAIL simul_cause_hold: got %0d expected 1", cause); end
        btn_rst = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_download();
        int hi, c;
        downloading = 1'b1;
        wdog_en = 1'b1;
        hi = 0;
        repeat (200) begin tick(); if (rst_req) hi++; end
        checks++;
        if (hi !== 0) begin failures++; $display("FAIL dl_wdog_suppressed: got %0d high cycles expected 0", hi); end
        osd_rst = 1'b1;
        tick();
        osd_rst = 1'b0;
        checks++;
        if (rst_req !== 1'b1) begin failures++; $display("FAIL dl_osd_req: got %b expected 1", rst_req); end
        checks++;
        if (cause !== 2'd2) begin failures++; $display("FAIL dl_osd_cause: got %0d expected 2", cause); end
        c = 0;
        while (busy && c < 60) begin tick(); c++; end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL dl_busy_timeout: got %b expected 0", busy); end
        downloading = 1'b0;
        wdog_en = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int w, c;
        osd_rst = 1'b1;
        tick();
        osd_rst = 1'b0;
        tick();
        tick();
        checks++;
        if (rst_req !== 1'b1) begin failures++; $display("FAIL mid_pre_req: got %b expected 1", rst_req); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (rst_req !== 1'b0) begin failures++; $display("FAIL mid_rst_req: got %b expected 0", rst_req); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy: got %b expected 0", busy); end
        checks++;
        if (cause !== 2'd0) begin failures++; $display("FAIL mid_cause: got %0d expected 0", cause); end
        osd_rst = 1'b1;
        tick();
        osd_rst = 1'b0;
        w = 0;
        while (rst_req && w < 40) begin w++; tick(); end
        checks++;
        if (w !== 8) begin failures++; $display("FAIL mid_fresh_width: got %0d expected 8", w); end
        checks++;
        if (cause !== 2'd2) begin failures++; $display("FAIL mid_fresh_cause: got %0d expected 2", cause); end
        c = 0;
        while (busy && c < 60) begin tick(); c++; end
    endtask

    initial begin
        test_reset();
        test_button();
        test_osd_cool();
        test_watchdog();
        test_simultaneous();
        test_download();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
